bambu_mem_initiator: RTL

BAMBU_MEM_INITIATOR -- requirements
Module: bambu_mem_initiator

---
 rtl/bambu_mem_initiator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bambu_mem_initiator.sv
// Single-outstanding memory initiator: accepts one command, drives a read or
// write strobe towards a memory responder until it completes or times out,
// then holds a response until the consumer takes it.
module bambu_mem_initiator #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen at the edge that closes the last allowed strobe cycle.
    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

    state_t            state;
    logic [15:0]       cycle_cnt;
    logic              size_ok;
    logic [DATA_W-1:0] read_mask;

    // Handshake flags are pure decodes of the state register.
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Only sizes 1..DATA_W describe a real access.
    assign size_ok = (cmd_size != '0) && (32'(cmd_size) <= 32'(DATA_W));

    // Low 'size' bits set; a shift by DATA_W empties the word, so the full
    // width case falls out as an all-ones mask without a special case.
    assign read_mask = ~({DATA_W{1'b1}} << Mout_data_ram_size);

    // Main FSM: state, timeout counter and every registered output.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the pre-edge value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // Strobes and the pending response drop immediately; nothing is
            // remembered about an aborted access.
            state              <= IDLE;
            cycle_cnt          <= '0;
            rsp_rdata          <= '0;
            rsp_error          <= 1'b0;
            Mout_oe_ram        <= 1'b0;
            Mout_we_ram        <= 1'b0;
            Mout_addr_ram      <= '0;
            Mout_Wdata_ram     <= '0;
            Mout_data_ram_size <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (size_ok) begin
                            state              <= REQ;
                            cycle_cnt          <= '0;
                            Mout_oe_ram        <= !cmd_write;
                            Mout_we_ram        <= cmd_write;
                            Mout_addr_ram      <= cmd_addr;
                            Mout_Wdata_ram     <= cmd_wdata;
                            Mout_data_ram_size <= cmd_size;
                        end else begin
                            // Bad size: answer with an error, never strobe.
                            state     <= RESP;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end

                REQ: begin
                    if (M_DataRdy || (cycle_cnt == LAST_CYCLE)) begin
                        // Completion takes priority over an expiring timeout.
                        state              <= RESP;
                        rsp_error          <= !M_DataRdy;
                        rsp_rdata          <= (M_DataRdy && Mout_oe_ram)
                                              ? (M_Rdata_ram & read_mask) : '0;
                        Mout_oe_ram        <= 1'b0;
                        Mout_we_ram        <= 1'b0;
                        Mout_addr_ram      <= '0;
                        Mout_Wdata_ram     <= '0;
                        Mout_data_ram_size <= '0;
                    end else begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
